// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_ctrl
// Brief    : Time-multiplexed switch debouncer with a round-robin event port.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_scan_ctrl #(
    parameter int N_CH      = 8,
    parameter int N_BOUNCE  = 3,
    parameter int TICK_DIV  = 16,
    parameter int IS_PULLUP = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         i_sig,
    output logic [N_CH-1:0]         o_sig_debounced,
    output logic                    o_evt_valid,
    input  logic                    i_evt_ready,
    output logic [$clog2(N_CH)-1:0] o_evt_ch,
    output logic                    o_evt_press,
    output logic                    o_evt_drop
);

    localparam int                c_IW        = $clog2(N_CH);
    localparam int                c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic              c_OFF       = (IS_PULLUP != 0);
    localparam logic [c_PW-1:0]   c_TICK_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_IW-1:0]   c_LAST_CH   = c_IW'(N_CH - 1);
    localparam logic [c_IW-1:0]   c_IDX_ONE   = c_IW'(1);
    localparam logic [c_PW-1:0]   c_PW_ONE    = c_PW'(1);
    localparam logic [N_BOUNCE:0] c_CNT_ONE   = (N_BOUNCE + 1)'(1);
    localparam logic [c_IW:0]     c_NCH_EXT   = (c_IW + 1)'(N_CH);

    generate
        if (TICK_DIV <= N_CH) begin : g_bad_tick_div
            $error("debounce_scan_ctrl: TICK_DIV (%0d) must exceed N_CH (%0d)", TICK_DIV, N_CH);
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            state_q;
    logic [c_PW-1:0]   presc_q;
    logic [c_IW-1:0]   idx_q;
    logic [c_IW-1:0]   ptr_q;
    logic [N_CH-1:0]   sync1_q;
    logic [N_CH-1:0]   sync2_q;
    logic [N_CH-1:0]   last_q;
    logic [N_CH-1:0]   deb_q;
    logic [N_CH-1:0]   pend_q;
    logic [N_CH-1:0]   pol_q;
    logic [N_BOUNCE:0] cnt_q [N_CH];
    logic              evt_valid_q;
    logic [c_IW-1:0]   evt_ch_q;
    logic              evt_press_q;
    logic              drop_q;

    logic [N_CH-1:0]   pend_d;
    logic              drop_d;

    logic              w_tick;
    logic              w_scan;
    logic              w_sel_sync;
    logic              w_sel_last;
    logic [N_BOUNCE:0] w_sel_cnt;
    logic [N_BOUNCE:0] w_cnt_nxt;
    logic              w_commit;
    logic [N_CH-1:0]   w_set;
    logic [N_CH-1:0]   w_clr;
    logic              w_free;
    logic              w_gnt_found;
    logic [c_IW-1:0]   w_gnt_idx;
    logic [c_IW:0]     w_sum;
    logic [c_IW-1:0]   w_cand;

    assign w_tick = (presc_q == c_TICK_LAST);
    assign w_scan = (state_q == S_SCAN);

    // Shared debounce datapath: only the channel under idx_q is examined.
    always_comb begin
        w_sel_sync = sync2_q[idx_q];
        w_sel_last = last_q[idx_q];
        w_sel_cnt  = cnt_q[idx_q];
        if (w_sel_sync != w_sel_last) begin
            w_cnt_nxt = c_CNT_ONE;
        end else if (w_sel_cnt[N_BOUNCE]) begin
            w_cnt_nxt = w_sel_cnt;
        end else begin
            w_cnt_nxt = w_sel_cnt + c_CNT_ONE;
        end
        w_commit = w_scan && w_sel_cnt[N_BOUNCE] && (w_sel_last != deb_q[idx_q]);
        w_set    = '0;
        if (w_commit) begin
            w_set[idx_q] = 1'b1;
        end
    end

    // Circular search for the first pending channel at or after ptr_q.
    always_comb begin
        w_free      = !evt_valid_q || i_evt_ready;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = {1'b0, ptr_q} + (c_IW + 1)'(i);
            if (w_sum >= c_NCH_EXT) begin
                w_sum = w_sum - c_NCH_EXT;
            end
            w_cand = w_sum[c_IW-1:0];
            if (!w_gnt_found && pend_q[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
        w_clr = '0;
        if (w_free && w_gnt_found) begin
            w_clr[w_gnt_idx] = 1'b1;
        end
        // A new scan event beats a same-cycle grant; only an unreported one counts as lost.
        pend_d = (pend_q & ~w_clr) | w_set;
        drop_d = drop_q | (w_commit && pend_q[idx_q] && !w_clr[idx_q]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            sync1_q     <= {N_CH{c_OFF}};
            sync2_q     <= {N_CH{c_OFF}};
            last_q      <= {N_CH{c_OFF}};
            deb_q       <= {N_CH{c_OFF}};
            pend_q      <= '0;
            pol_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_press_q <= 1'b0;
            drop_q      <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= c_CNT_ONE;
            end
        end else begin
            sync1_q <= i_sig;
            sync2_q <= sync1_q;
            presc_q <= w_tick ? '0 : presc_q + c_PW_ONE;
            pend_q  <= pend_d;
            drop_q  <= drop_d;

            case (state_q)
                S_IDLE: begin
                    if (w_tick) begin
                        state_q <= S_SCAN;
                        idx_q   <= '0;
                    end
                end
                S_SCAN: begin
                    last_q[idx_q] <= w_sel_sync;
                    cnt_q[idx_q]  <= w_cnt_nxt;
                    if (w_commit) begin
                        deb_q[idx_q] <= w_sel_last;
                        pol_q[idx_q] <= (w_sel_last != c_OFF);
                    end
                    if (idx_q == c_LAST_CH) begin
                        state_q <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + c_IDX_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (w_free) begin
                if (w_gnt_found) begin
                    evt_valid_q <= 1'b1;
                    evt_ch_q    <= w_gnt_idx;
                    evt_press_q <= pol_q[w_gnt_idx];
                    ptr_q       <= (w_gnt_idx == c_LAST_CH) ? '0 : w_gnt_idx + c_IDX_ONE;
                end else begin
                    evt_valid_q <= 1'b0;
                end
            end
        end
    end

    assign o_sig_debounced = deb_q;
    assign o_evt_valid     = evt_valid_q;
    assign o_evt_ch        = evt_ch_q;
    assign o_evt_press     = evt_press_q;
    assign o_evt_drop      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_scan_ctrl
// Brief    : Self-checking bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_scan_ctrl;

    localparam int   N_CH      = 8;
    localparam int   N_BOUNCE  = 3;
    localparam int   TICK_DIV  = 16;
    localparam int   IS_PULLUP = 0;
    localparam int   IW        = $clog2(N_CH);
    localparam logic c_OFF     = (IS_PULLUP != 0);
    localparam int   c_THRESH  = 2 ** N_BOUNCE;

    logic            clk         = 1'b0;
    logic            rstn        = 1'b0;
    logic            i_evt_ready = 1'b0;
    logic [N_CH-1:0] i_sig       = '0;
    logic [N_CH-1:0] o_sig_debounced;
    logic            o_evt_valid;
    logic [IW-1:0]   o_evt_ch;
    logic            o_evt_press;
    logic            o_evt_drop;

    debounce_scan_ctrl #(
        .N_CH      (N_CH),
        .N_BOUNCE  (N_BOUNCE),
        .TICK_DIV  (TICK_DIV),
        .IS_PULLUP (IS_PULLUP)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_sig           (i_sig),
        .o_sig_debounced (o_sig_debounced),
        .o_evt_valid     (o_evt_valid),
        .i_evt_ready     (i_evt_ready),
        .o_evt_ch        (o_evt_ch),
        .o_evt_press     (o_evt_press),
        .o_evt_drop      (o_evt_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;
    int n_hs5    = 0;
    int last_ch  = 0;
    int last_pr  = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is sampled once per scan tick, at the
    // cycle whose prescaler phase equals its index; run = equal-sample streak.
    logic [N_CH-1:0] m_sync1, m_sync2, m_val, m_deb, m_pend, m_pol;
    int              m_run [N_CH];
    int              m_presc, m_ptr, m_ch, m_g, m_j, m_k;
    bit              m_ticked;
    logic            m_valid, m_press, m_drop;

    always @(posedge clk) begin
        if (!rstn) begin
            m_sync1 = {N_CH{c_OFF}};
            m_sync2 = {N_CH{c_OFF}};
            m_val   = {N_CH{c_OFF}};
            m_deb   = {N_CH{c_OFF}};
            m_pend  = '0;
            m_pol   = '0;
            for (int k = 0; k < N_CH; k++) m_run[k] = 1;
            m_presc = 0; m_ptr = 0; m_ch = 0; m_ticked = 1'b0;
            m_valid = 1'b0; m_press = 1'b0; m_drop = 1'b0;
        end else begin
            if (!m_valid || i_evt_ready) begin
                m_g = -1;
                for (int i = 0; i < N_CH; i++) begin
                    m_j = (m_ptr + i) % N_CH;
                    if (m_g < 0 && m_pend[m_j]) m_g = m_j;
                end
                if (m_g >= 0) begin
                    m_valid = 1'b1;
                    m_ch    = m_g;
                    m_press = m_pol[m_g];
                    m_pend[m_g] = 1'b0;
                    m_ptr   = (m_g + 1) % N_CH;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (m_ticked && m_presc < N_CH) begin
                m_k = m_presc;
                if (m_run[m_k] >= c_THRESH && m_val[m_k] != m_deb[m_k]) begin
                    m_deb[m_k] = m_val[m_k];
                    if (m_pend[m_k]) m_drop = 1'b1;
                    m_pend[m_k] = 1'b1;
                    m_pol[m_k]  = (m_val[m_k] != c_OFF);
                end
                if (m_sync2[m_k] == m_val[m_k]) begin
                    m_run[m_k] = m_run[m_k] + 1;
                end else begin
                    m_val[m_k] = m_sync2[m_k];
                    m_run[m_k] = 1;
                end
            end
            if (m_presc == TICK_DIV - 1) m_ticked = 1'b1;
            m_presc = (m_presc + 1) % TICK_DIV;
            m_sync2 = m_sync1;
            m_sync1 = i_sig;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("model_deb",   o_sig_debounced, m_deb);
            check("model_valid", o_evt_valid, m_valid);
            check("model_ch",    o_evt_ch, m_ch);
            check("model_press", o_evt_press, m_press);
            check("model_drop",  o_evt_drop, m_drop);
        end
        if (rstn && o_evt_valid && i_evt_ready) begin
            n_hs++;
            last_ch = o_evt_ch;
            last_pr = o_evt_press;
            if (o_evt_ch == IW'(5) && o_evt_press) n_hs5++;
        end
    end

    // Leaves the bench in cycle 0: the first cycle after the last reset edge.
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rstn        = 1'b0;
        i_sig       = {N_CH{c_OFF}};
        i_evt_ready = rdy;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [N_CH-1:0] sig;
        int              ncyc;
        logic [N_CH-1:0] exp_deb;
        int              exp_nevt;
    } vec_t;

    vec_t vecs [9];
    int   hs0, hs5_0, rdy_mode, rch;
    logic seen_hi;

    initial begin
        vecs[0] = '{sig: 8'h00, ncyc: 2000, exp_deb: 8'h00, exp_nevt: 0};
        vecs[1] = '{sig: 8'h08, ncyc: 48,   exp_deb: 8'h00, exp_nevt: 0};
        vecs[2] = '{sig: 8'h08, ncyc: 160,  exp_deb: 8'h08, exp_nevt: 1};
        vecs[3] = '{sig: 8'h00, ncyc: 208,  exp_deb: 8'h00, exp_nevt: 1};
        vecs[4] = '{sig: 8'hA5, ncyc: 208,  exp_deb: 8'hA5, exp_nevt: 4};
        vecs[5] = '{sig: 8'h5A, ncyc: 64,   exp_deb: 8'hA5, exp_nevt: 0};
        vecs[6] = '{sig: 8'h5A, ncyc: 160,  exp_deb: 8'h5A, exp_nevt: 8};
        vecs[7] = '{sig: 8'hFF, ncyc: 208,  exp_deb: 8'hFF, exp_nevt: 4};
        vecs[8] = '{sig: 8'h00, ncyc: 208,  exp_deb: 8'h00, exp_nevt: 8};

        do_reset(1'b1);
        mon_en = 1'b1;
        check("rst_deb",   o_sig_debounced, 8'h00);
        check("rst_valid", o_evt_valid, 1'b0);
        check("rst_ch",    o_evt_ch, 0);
        check("rst_press", o_evt_press, 1'b0);
        check("rst_drop",  o_evt_drop, 1'b0);

        for (int r = 0; r < 9; r++) begin
            hs0   = n_hs;
            i_sig = vecs[r].sig;
            repeat (vecs[r].ncyc) @(negedge clk);
            check($sformatf("vec%0d_deb", r),  o_sig_debounced, vecs[r].exp_deb);
            check($sformatf("vec%0d_drop", r), o_evt_drop, 1'b0);
            check($sformatf("vec%0d_nevt", r), n_hs - hs0, vecs[r].exp_nevt);
        end

        // Clean press on ch3: last sample cycle 147, level visible at 148, event at 149.
        do_reset(1'b1);
        i_sig = 8'h08;
        repeat (147) @(negedge clk);
        check("press3_deb_before", o_sig_debounced, 8'h00);
        @(negedge clk);
        check("press3_deb_after", o_sig_debounced, 8'h08);
        check("press3_valid_lat", o_evt_valid, 1'b0);
        @(negedge clk);
        check("press3_valid", o_evt_valid, 1'b1);
        check("press3_ch",    o_evt_ch, 3);
        check("press3_press", o_evt_press, 1'b1);
        @(negedge clk);
        check("press3_taken", o_evt_valid, 1'b0);
        hs0   = n_hs;
        i_sig = 8'h00;
        repeat (200) @(negedge clk);
        check("release3_deb",   o_sig_debounced, 8'h00);
        check("release3_nevt",  n_hs - hs0, 1);
        check("release3_ch",    last_ch, 3);
        check("release3_press", last_pr, 0);

        // Bounce on ch5: two ticks per level never reaches the threshold.
        do_reset(1'b1);
        hs0     = n_hs;
        hs5_0   = n_hs5;
        seen_hi = 1'b0;
        for (int t = 0; t < 10; t++) begin
            i_sig[5] = ~i_sig[5];
            repeat (32) begin
                @(negedge clk);
                seen_hi = seen_hi | o_sig_debounced[5];
            end
        end
        check("bounce_no_change", seen_hi, 1'b0);
        i_sig[5] = 1'b1;
        repeat (200) @(negedge clk);
        check("bounce_deb",   o_sig_debounced[5], 1'b1);
        check("bounce_nevt",  n_hs - hs0, 1);
        check("bounce_press", n_hs5 - hs5_0, 1);

        // Arbitration: all channels at once, stalled, then drained in order.
        do_reset(1'b0);
        i_sig = 8'hFF;
        repeat (160) @(negedge clk);
        check("arb_stall_valid", o_evt_valid, 1'b1);
        check("arb_stall_ch",    o_evt_ch, 0);
        repeat (10) @(negedge clk);
        check("arb_hold_ch",    o_evt_ch, 0);
        check("arb_hold_press", o_evt_press, 1'b1);
        i_evt_ready = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("arb_drain%0d_valid", c), o_evt_valid, 1'b1);
            check($sformatf("arb_drain%0d_ch", c), o_evt_ch, c);
            @(negedge clk);
        end
        check("arb_empty", o_evt_valid, 1'b0);
        check("arb_drop",  o_evt_drop, 1'b0);

        // Drop: ch0 holds the output register while ch2 presses then releases.
        do_reset(1'b0);
        i_sig = 8'h05;
        repeat (200) @(negedge clk);
        i_sig = 8'h01;
        repeat (200) @(negedge clk);
        check("drop_deb",   o_sig_debounced, 8'h01);
        check("drop_flag",  o_evt_drop, 1'b1);
        check("drop_ev0",   {o_evt_valid, 5'(o_evt_ch), o_evt_press}, {1'b1, 5'd0, 1'b1});
        i_evt_ready = 1'b1;
        @(negedge clk);
        check("drop_ev1",   {o_evt_valid, 5'(o_evt_ch), o_evt_press}, {1'b1, 5'd2, 1'b0});
        @(negedge clk);
        check("drop_empty", o_evt_valid, 1'b0);
        check("drop_sticky", o_evt_drop, 1'b1);

        // Reset during a scan cycle with an event presented.
        do_reset(1'b0);
        i_sig = 8'h01;
        repeat (163) @(negedge clk);
        check("midrst_pre_valid", o_evt_valid, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_deb",   o_sig_debounced, 8'h00);
        check("midrst_valid", o_evt_valid, 1'b0);
        check("midrst_ch",    o_evt_ch, 0);
        check("midrst_press", o_evt_press, 1'b0);
        check("midrst_drop",  o_evt_drop, 1'b0);
        rstn = 1'b1;
        repeat (144) @(negedge clk);
        check("midrst_restart_before", o_sig_debounced[0], 1'b0);
        @(negedge clk);
        check("midrst_restart_after", o_sig_debounced[0], 1'b1);

        // Random inputs and backpressure against the model.
        do_reset(1'b1);
        rdy_mode = 1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(24) == 0) begin
                rch   = int'($urandom_range(N_CH - 1));
                i_sig = i_sig ^ (N_CH'(1) << rch);
            end
            if (cyc % 256 == 0) rdy_mode = int'($urandom_range(3));
            i_evt_ready = (rdy_mode == 0) ? 1'b0 : ($urandom_range(3) != 0);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
